// File: rtl/wb_trace_pkg.sv
// Shared helpers for the Wishbone trace buffer: entry layout and width helpers.
// Entry layout, MSB to LSB: {ch, we, adr, dat, ts}.
package wb_trace_pkg;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned entry_width(input int unsigned chw, input int unsigned adr_w,
                                              input int unsigned dat_w, input int unsigned ts_w);
    return chw + 1 + adr_w + dat_w + ts_w;
  endfunction

  localparam int unsigned TsOff = 0;

  function automatic int unsigned dat_off(input int unsigned ts_w);
    return TsOff + ts_w;
  endfunction

  function automatic int unsigned adr_off(input int unsigned ts_w, input int unsigned dat_w);
    return dat_off(ts_w) + dat_w;
  endfunction

  function automatic int unsigned we_off(input int unsigned ts_w, input int unsigned dat_w,
                                         input int unsigned adr_w);
    return adr_off(ts_w, dat_w) + adr_w;
  endfunction

  function automatic int unsigned ch_off(input int unsigned ts_w, input int unsigned dat_w,
                                         input int unsigned adr_w);
    return we_off(ts_w, dat_w, adr_w) + 1;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Generic first-word-fall-through FIFO; head is read combinationally from storage.
module wb_trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Snoops N_CH Wishbone masters, holds one pending entry per channel and arbitrates
// them round-robin into a trace FIFO drained through a valid/ready port.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned N_CH  = 2,
  parameter int unsigned ADR_W = 32,
  parameter int unsigned DAT_W = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned TS_W  = 16,
  parameter int unsigned OVF_W = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          clear,
  input  logic [N_CH-1:0]               ch_ack,
  input  logic [N_CH-1:0]               ch_we,
  input  logic [N_CH*ADR_W-1:0]         ch_adr,
  input  logic [N_CH*DAT_W-1:0]         ch_dat_w,
  input  logic [N_CH*DAT_W-1:0]         ch_dat_r,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [clog2_min1(N_CH)-1:0]   rd_ch,
  output logic                          rd_we,
  output logic [ADR_W-1:0]              rd_adr,
  output logic [DAT_W-1:0]              rd_dat,
  output logic [TS_W-1:0]               rd_ts,
  output logic [$clog2(DEPTH):0]        level,
  output logic [OVF_W-1:0]              overflow_cnt
);

  localparam int unsigned CHW    = clog2_min1(N_CH);
  localparam int unsigned EW     = entry_width(CHW, ADR_W, DAT_W, TS_W);
  localparam int unsigned OffDat = dat_off(TS_W);
  localparam int unsigned OffAdr = adr_off(TS_W, DAT_W);
  localparam int unsigned OffWe  = we_off(TS_W, DAT_W, ADR_W);
  localparam int unsigned OffCh  = ch_off(TS_W, DAT_W, ADR_W);

  logic [N_CH-1:0]  slot_vld_q, slot_vld_d;
  logic [EW-1:0]    slot_q [N_CH];
  logic [EW-1:0]    slot_d [N_CH];
  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CHW-1:0]   rr_q, rr_d;
  logic [OVF_W-1:0] ovf_q, ovf_d;
  logic [OVF_W:0]   ovf_sum;
  logic [CHW:0]     drops;

  logic             gnt_vld;
  logic [CHW-1:0]   gnt_idx;
  logic [CHW-1:0]   scan_idx;
  logic             push, pop, fifo_full, fifo_empty;
  logic [EW-1:0]    head;

  // First occupied slot strictly after the last granted channel, wrapping.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int unsigned k = 1; k <= N_CH; k++) begin
      scan_idx = CHW'((32'(rr_q) + k) % N_CH);
      if (!gnt_vld && slot_vld_q[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end
  end

  assign pop  = rd_valid && rd_ready && !clear;
  assign push = gnt_vld && (!fifo_full || pop) && !clear;

  always_comb begin
    slot_vld_d = slot_vld_q;
    rr_d       = rr_q;
    drops      = '0;
    for (int i = 0; i < int'(N_CH); i++) slot_d[i] = slot_q[i];
    if (push) begin
      rr_d                = gnt_idx;
      slot_vld_d[gnt_idx] = 1'b0;
    end
    // A slot freed by this cycle's grant can be refilled at the same edge.
    for (int i = 0; i < int'(N_CH); i++) begin
      if (enable && ch_ack[i]) begin
        if (!slot_vld_d[i]) begin
          slot_vld_d[i] = 1'b1;
          slot_d[i]     = {CHW'(i), ch_we[i], ch_adr[i*ADR_W +: ADR_W],
                           ch_we[i] ? ch_dat_w[i*DAT_W +: DAT_W] : ch_dat_r[i*DAT_W +: DAT_W],
                           ts_q};
        end else begin
          drops = drops + (CHW + 1)'(1);
        end
      end
    end
    ovf_sum = {1'b0, ovf_q} + (OVF_W + 1)'(drops);
    ovf_d   = ovf_sum[OVF_W] ? '1 : ovf_sum[OVF_W-1:0];
    ts_d    = ts_q + 1'b1;
    if (clear) begin
      slot_vld_d = '0;
      ovf_d      = '0;
      ts_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_vld_q <= '0;
      for (int i = 0; i < int'(N_CH); i++) slot_q[i] <= '0;
      ts_q       <= '0;
      rr_q       <= CHW'(N_CH - 1);
      ovf_q      <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      for (int i = 0; i < int'(N_CH); i++) slot_q[i] <= slot_d[i];
      ts_q       <= ts_d;
      rr_q       <= rr_d;
      ovf_q      <= ovf_d;
    end
  end

  wb_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .push      (push),
    .push_data (slot_q[gnt_idx]),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rd_valid     = !fifo_empty;
  assign rd_ch        = head[OffCh +: CHW];
  assign rd_we        = head[OffWe];
  assign rd_adr       = head[OffAdr +: ADR_W];
  assign rd_dat       = head[OffDat +: DAT_W];
  assign rd_ts        = head[TsOff +: TS_W];
  assign overflow_cnt = ovf_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer (N_CH=2, DEPTH=16, TS_W=4 to exercise wrap).
module tb_wb_trace_buffer;

  localparam int unsigned NCh   = 2;
  localparam int unsigned AdrW  = 32;
  localparam int unsigned DatW  = 32;
  localparam int unsigned Depth = 16;
  localparam int unsigned TsW   = 4;
  localparam int unsigned OvfW  = 16;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic                 enable;
  logic                 clear;
  logic [NCh-1:0]       ch_ack;
  logic [NCh-1:0]       ch_we;
  logic [NCh*AdrW-1:0]  ch_adr;
  logic [NCh*DatW-1:0]  ch_dat_w;
  logic [NCh*DatW-1:0]  ch_dat_r;
  logic                 rd_valid;
  logic                 rd_ready;
  logic                 rd_ch;
  logic                 rd_we;
  logic [AdrW-1:0]      rd_adr;
  logic [DatW-1:0]      rd_dat;
  logic [TsW-1:0]       rd_ts;
  logic [4:0]           level;
  logic [OvfW-1:0]      overflow_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_trace_buffer #(
    .N_CH  (NCh),
    .ADR_W (AdrW),
    .DAT_W (DatW),
    .DEPTH (Depth),
    .TS_W  (TsW),
    .OVF_W (OvfW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .clear        (clear),
    .ch_ack       (ch_ack),
    .ch_we        (ch_we),
    .ch_adr       (ch_adr),
    .ch_dat_w     (ch_dat_w),
    .ch_dat_r     (ch_dat_r),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_ch        (rd_ch),
    .rd_we        (rd_we),
    .rd_adr       (rd_adr),
    .rd_dat       (rd_dat),
    .rd_ts        (rd_ts),
    .level        (level),
    .overflow_cnt (overflow_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_inputs();
    ch_ack   = '0;
    ch_we    = '0;
    ch_adr   = '0;
    ch_dat_w = '0;
    ch_dat_r = '0;
    clear    = 1'b0;
  endtask

  // Reset is released on a falling edge, so the next rising edge sees ts=0.
  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    enable   = 1'b1;
    rd_ready = 1'b0;
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic set_ch(input int ch, input logic we, input logic [31:0] adr,
                        input logic [31:0] dw, input logic [31:0] dr);
    ch_ack[ch]              = 1'b1;
    ch_we[ch]               = we;
    ch_adr[ch*AdrW +: AdrW] = adr;
    ch_dat_w[ch*DatW +: DatW] = dw;
    ch_dat_r[ch*DatW +: DatW] = dr;
  endtask

  initial begin
    int exp_ts[3];
    exp_ts = '{14, 0, 0};
    exp_ts[1] = 15;

    // Reset state
    reset_n = 1'b0;
    idle_inputs();
    enable   = 1'b1;
    rd_ready = 1'b0;
    tick(2);
    check("rst_valid", 64'(rd_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_ovf", 64'(overflow_cnt), 64'd0);
    check("rst_adr", 64'(rd_adr), 64'd0);
    check("rst_dat", 64'(rd_dat), 64'd0);
    check("rst_ts", 64'(rd_ts), 64'd0);

    // Single read on ch0 at ts=5
    do_reset();
    rd_ready = 1'b1;
    tick(5);
    set_ch(0, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF);
    tick(1);
    idle_inputs();
    check("t1_valid_t1", 64'(rd_valid), 64'd0);
    tick(1);
    check("t1_valid_t2", 64'(rd_valid), 64'd1);
    check("t1_ch", 64'(rd_ch), 64'd0);
    check("t1_we", 64'(rd_we), 64'd0);
    check("t1_adr", 64'(rd_adr), 64'h100);
    check("t1_dat", 64'(rd_dat), 64'hDEAD_BEEF);
    check("t1_ts", 64'(rd_ts), 64'd5);
    tick(1);
    check("t1_popped", 64'(rd_valid), 64'd0);

    // Simultaneous ch0 write and ch1 read
    do_reset();
    rd_ready = 1'b1;
    set_ch(0, 1'b1, 32'h40, 32'h11, 32'h99);
    set_ch(1, 1'b0, 32'h80, 32'h77, 32'h22);
    tick(1);
    idle_inputs();
    tick(1);
    check("t2_first_valid", 64'(rd_valid), 64'd1);
    check("t2_first_ch", 64'(rd_ch), 64'd0);
    check("t2_first_we", 64'(rd_we), 64'd1);
    check("t2_first_dat", 64'(rd_dat), 64'h11);
    check("t2_first_ts", 64'(rd_ts), 64'd0);
    tick(1);
    check("t2_second_valid", 64'(rd_valid), 64'd1);
    check("t2_second_ch", 64'(rd_ch), 64'd1);
    check("t2_second_adr", 64'(rd_adr), 64'h80);
    check("t2_second_dat", 64'(rd_dat), 64'h22);
    check("t2_second_ts", 64'(rd_ts), 64'd0);
    check("t2_ovf", 64'(overflow_cnt), 64'd0);
    tick(1);
    check("t2_drained", 64'(rd_valid), 64'd0);

    // Acks ignored while enable is low
    do_reset();
    enable = 1'b0;
    set_ch(0, 1'b0, 32'h1, 32'h0, 32'h1);
    tick(1);
    idle_inputs();
    tick(3);
    check("en_low_level", 64'(level), 64'd0);
    enable = 1'b1;

    // Round-robin fairness: both channels ack every cycle for 8 cycles
    do_reset();
    rd_ready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      if (k >= 2) begin
        check($sformatf("rr_valid_c%0d", k), 64'(rd_valid), 64'd1);
        check($sformatf("rr_ch_c%0d", k), 64'(rd_ch), (k % 2 == 0) ? 64'd0 : 64'd1);
      end
      if (k >= 1 && k <= 9)
        check($sformatf("rr_ovf_c%0d", k), 64'(overflow_cnt), (k - 1 < 7) ? 64'(k - 1) : 64'd7);
      if (k < 8) begin
        set_ch(0, 1'b0, 32'(k), 32'h0, 32'(k));
        set_ch(1, 1'b0, 32'(k), 32'h0, 32'(k));
      end else begin
        idle_inputs();
      end
      tick(1);
    end

    // Fill: 20 single-channel acks with the reader stalled
    do_reset();
    for (int k = 0; k < 20; k++) begin
      set_ch(0, 1'b0, 32'(k), 32'h0, 32'(k));
      tick(1);
    end
    idle_inputs();
    check("fill_level", 64'(level), 64'd16);
    check("fill_ovf", 64'(overflow_cnt), 64'd3);
    check("fill_head_adr", 64'(rd_adr), 64'd0);
    check("fill_head_ts", 64'(rd_ts), 64'd0);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check("fill_pop_push_level", 64'(level), 64'd16);
    check("fill_next_adr", 64'(rd_adr), 64'd1);
    check("fill_next_ts", 64'(rd_ts), 64'd1);
    tick(1);
    check("fill_hold_level", 64'(level), 64'd16);
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check("fill_slot_freed", 64'(level), 64'd15);
    check("fill_ovf_hold", 64'(overflow_cnt), 64'd3);

    // Clear with level=7, overflow=4 and a simultaneous ack
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_ch(0, 1'b0, 32'h10, 32'h0, 32'h0);
      set_ch(1, 1'b0, 32'h20, 32'h0, 32'h0);
      tick(1);
    end
    idle_inputs();
    tick(3);
    set_ch(0, 1'b0, 32'h30, 32'h0, 32'h0);
    tick(1);
    idle_inputs();
    tick(3);
    check("clr_pre_level", 64'(level), 64'd7);
    check("clr_pre_ovf", 64'(overflow_cnt), 64'd4);
    clear = 1'b1;
    set_ch(0, 1'b0, 32'h555, 32'h0, 32'h0);
    set_ch(1, 1'b0, 32'h556, 32'h0, 32'h0);
    tick(1);
    idle_inputs();
    check("clr_level", 64'(level), 64'd0);
    check("clr_valid", 64'(rd_valid), 64'd0);
    check("clr_ovf", 64'(overflow_cnt), 64'd0);
    set_ch(0, 1'b0, 32'hABC, 32'h0, 32'h0);
    tick(1);
    idle_inputs();
    tick(1);
    check("clr_after_level", 64'(level), 64'd1);
    check("clr_after_adr", 64'(rd_adr), 64'hABC);
    check("clr_after_ts", 64'(rd_ts), 64'd0);

    // Timestamp wrap with TS_W=4: acks at cycles 14, 15, 16
    do_reset();
    tick(14);
    for (int k = 14; k <= 16; k++) begin
      set_ch(0, 1'b0, 32'(k), 32'h0, 32'h0);
      tick(1);
    end
    idle_inputs();
    tick(3);
    check("wrap_level", 64'(level), 64'd3);
    for (int j = 0; j < 3; j++) begin
      check($sformatf("wrap_ts%0d", j), 64'(rd_ts), 64'(exp_ts[j]));
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
    end
    check("wrap_empty", 64'(rd_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
